// File: rtl/rvv_backend_div_unit_sequencer.sv
// -----------------------------------------------------------------------------
// rvv_backend_div_unit_sequencer
//
// Issue-side controller for the iterative element divider. A uop of NUM_ELEM
// packed elements is captured in IDLE, its elements are fed to the divider one
// at a time in ISSUE, and the packed quotient/remainder result is presented in
// DONE until the consumer accepts it.
//
// Optional feature macro: DIV_SEQ_MASK_SKIP_EN
//   defined   : masked-off elements are never sent to the divider; an
//               all-masked uop goes straight from IDLE to DONE.
//   undefined : every element is issued in order; masked results are dropped.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   uop_*               uop input handshake and operands (mask, signedness,
//                       quotient/remainder select, src2/src1/vd_old vectors)
//   div_valid/opcode/   element request to the divider (held until the
//   div_src2/div_src1   element's result handshake)
//   div_quotient/       element result from the divider
//   div_remainder/
//   div_res_valid/ready
//   res_valid/data/     packed result handshake to the consumer
//   res_ready
//   trap_flush_rvv      flush; abandons the uop and clears the result buffer
// -----------------------------------------------------------------------------
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef HWORD_WIDTH
`define HWORD_WIDTH 16
`endif
`ifndef BYTE_WIDTH
`define BYTE_WIDTH 8
`endif

module rvv_backend_div_unit_sequencer #(
  parameter int ELEM_WIDTH = `WORD_WIDTH,
  parameter int NUM_ELEM   = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           uop_valid,
  output logic                           uop_ready,
  input  logic                           uop_signed,
  input  logic                           uop_rem,
  input  logic [NUM_ELEM-1:0]            uop_vm,
  input  logic [NUM_ELEM*ELEM_WIDTH-1:0] uop_src2,
  input  logic [NUM_ELEM*ELEM_WIDTH-1:0] uop_src1,
  input  logic [NUM_ELEM*ELEM_WIDTH-1:0] uop_vd_old,
  output logic                           div_valid,
  output logic                           div_opcode,
  output logic [ELEM_WIDTH-1:0]          div_src2,
  output logic [ELEM_WIDTH-1:0]          div_src1,
  input  logic [ELEM_WIDTH-1:0]          div_quotient,
  input  logic [ELEM_WIDTH-1:0]          div_remainder,
  input  logic                           div_res_valid,
  output logic                           div_res_ready,
  output logic                           res_valid,
  output logic [NUM_ELEM*ELEM_WIDTH-1:0] res_data,
  input  logic                           res_ready,
  input  logic                           trap_flush_rvv
);

  localparam int IDX_W = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
  localparam int DW    = NUM_ELEM * ELEM_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IDX_W-1:0]      r_idx;
  logic [IDX_W-1:0]      w_idx_nxt;
  logic                  r_signed;
  logic                  r_rem;
  logic [NUM_ELEM-1:0]   r_vm;
  logic [DW-1:0]         r_src2;
  logic [DW-1:0]         r_src1;
  logic [DW-1:0]         r_buf;
  logic [DW-1:0]         w_buf_nxt;
  logic                  w_accept;
  logic                  w_issue;

`ifdef DIV_SEQ_MASK_SKIP_EN
  logic [IDX_W:0]        w_search;

  // Lowest set mask bit at or above from_idx; MSB of the result flags a hit.
  function automatic logic [IDX_W:0] f_next_active(input logic [NUM_ELEM-1:0] mask,
                                                   input int from_idx);
    logic [IDX_W:0] res;
    res = '0;
    for (int i = NUM_ELEM - 1; i >= 0; i--) begin
      if (mask[i] && (i >= from_idx)) begin
        res = {1'b1, IDX_W'(i)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction
`endif

  // Next-state, next-index and result-buffer update.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_buf_nxt   = r_buf;
    w_accept    = 1'b0;
`ifdef DIV_SEQ_MASK_SKIP_EN
    w_search    = '0;
`endif
    if (trap_flush_rvv) begin
      // Flush wins over everything, including a same-cycle uop or res_ready.
      w_state_nxt = S_IDLE;
      w_idx_nxt   = '0;
      w_buf_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (uop_valid) begin
            w_accept  = 1'b1;
            // Preload old destination; active elements are overwritten later.
            w_buf_nxt = uop_vd_old;
`ifdef DIV_SEQ_MASK_SKIP_EN
            w_search = f_next_active(uop_vm, 0);
            if (w_search[IDX_W]) begin
              w_state_nxt = S_ISSUE;
              w_idx_nxt   = w_search[IDX_W-1:0];
            end else begin
              w_state_nxt = S_DONE;
              w_idx_nxt   = '0;
            end
`else
            w_state_nxt = S_ISSUE;
            w_idx_nxt   = '0;
`endif
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_ISSUE: begin
          if (div_res_valid) begin
            if (r_vm[r_idx]) begin
              w_buf_nxt[int'(r_idx)*ELEM_WIDTH +: ELEM_WIDTH] = r_rem ? div_remainder : div_quotient;
            end else begin
              w_buf_nxt = r_buf;
            end
`ifdef DIV_SEQ_MASK_SKIP_EN
            w_search = f_next_active(r_vm, int'(r_idx) + 1);
            if (w_search[IDX_W]) begin
              w_idx_nxt = w_search[IDX_W-1:0];
            end else begin
              w_state_nxt = S_DONE;
              w_idx_nxt   = '0;
            end
`else
            if (r_idx == IDX_W'(NUM_ELEM - 1)) begin
              w_state_nxt = S_DONE;
              w_idx_nxt   = '0;
            end else begin
              w_idx_nxt = r_idx + IDX_W'(1);
            end
`endif
          end else begin
            w_state_nxt = S_ISSUE;
          end
        end
        S_DONE: begin
          if (res_ready) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_idx_nxt   = '0;
          w_buf_nxt   = '0;
        end
      endcase
    end
  end

  // FSM state, element index and result buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_buf   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_buf   <= w_buf_nxt;
    end
  end

  // Captured uop fields, loaded only when a uop is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_signed <= 1'b0;
      r_rem    <= 1'b0;
      r_vm     <= '0;
      r_src2   <= '0;
      r_src1   <= '0;
    end else if (w_accept) begin
      r_signed <= uop_signed;
      r_rem    <= uop_rem;
      r_vm     <= uop_vm;
      r_src2   <= uop_src2;
      r_src1   <= uop_src1;
    end else begin
      r_signed <= r_signed;
      r_rem    <= r_rem;
      r_vm     <= r_vm;
      r_src2   <= r_src2;
      r_src1   <= r_src1;
    end
  end

  // Outputs decode directly from registers so an async reset takes effect at once.
  assign w_issue       = (r_state == S_ISSUE);
  assign uop_ready     = (r_state == S_IDLE);
  assign div_valid     = w_issue;
  assign div_res_ready = w_issue;
  assign div_opcode    = w_issue & r_signed;
  assign div_src2      = w_issue ? r_src2[int'(r_idx)*ELEM_WIDTH +: ELEM_WIDTH] : '0;
  assign div_src1      = w_issue ? r_src1[int'(r_idx)*ELEM_WIDTH +: ELEM_WIDTH] : '0;
  assign res_valid     = (r_state == S_DONE);
  assign res_data      = r_buf;

endmodule

// File: doc/rvv_backend_div_unit_sequencer.md
Name: rvv_backend_div_unit_sequencer

Overview:
- Issue-side controller for the iterative element divider.
- Accepts one divide uop of NUM_ELEM packed elements from the div unit front end and drives elements to the divider one at a time, holding its valid/operand handshake.
- Collects the selected quotient or remainder per element into a result buffer and returns the packed result with a valid/ready handshake.
- Honours trap flush and per-element masking.

Parameters:
- ELEM_WIDTH, `WORD_WIDTH, element width; legal values are `WORD_WIDTH, `HWORD_WIDTH, `BYTE_WIDTH.
- NUM_ELEM, 4, elements per uop; ≥1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- uop_valid  in  1  uop present
- uop_ready  out  1  sequencer can accept uop
- uop_signed  in  1  1=signed (DIV_SIGN), 0=unsigned
- uop_rem  in  1  1=return remainder, 0=return quotient
- uop_vm  in  NUM_ELEM  element mask, 1=active
- uop_src2  in  NUM_ELEM*ELEM_WIDTH  dividends, element i at [i*ELEM_WIDTH +: ELEM_WIDTH]
- uop_src1  in  NUM_ELEM*ELEM_WIDTH  divisors
- uop_vd_old  in  NUM_ELEM*ELEM_WIDTH  old destination, used for masked-off elements
- div_valid  out  1  to divider
- div_opcode  out  1  to divider opcode
- div_src2  out  ELEM_WIDTH  dividend to divider
- div_src1  out  ELEM_WIDTH  divisor to divider
- div_quotient  in  ELEM_WIDTH  from divider
- div_remainder  in  ELEM_WIDTH  from divider
- div_res_valid  in  1  from divider
- div_res_ready  out  1  to divider
- res_valid  out  1  packed result valid
- res_data  out  NUM_ELEM*ELEM_WIDTH  packed result
- res_ready  in  1  consumer accepts
- trap_flush_rvv  in  1  flush, also wired to the divider

Behaviour:
- Reset: state=IDLE; idx=0; buffer=0.
- Reset outputs: uop_ready=1, div_valid=0, div_res_ready=0, res_valid=0, res_data=0, div_opcode=0, div_src2=0, div_src1=0.
- FSM states: IDLE, ISSUE, DONE.
- IDLE:
  - uop_ready=1.
  - On uop_valid & !trap_flush_rvv, register signed/rem/vm/src2/src1/vd_old; idx=first element to issue; go to ISSUE.
  - If no element needs issue, the buffer is filled from vd_old and the FSM goes to DONE.
- ISSUE:
  - uop_ready=0; div_valid=1 continuously; div_res_ready=1.
  - div_src2/div_src1/div_opcode come from registered element idx and stay stable until that element's result handshake.
  - On div_res_valid, buffer[idx] = uop_rem ? div_remainder : div_quotient.
  - If idx is the last element to issue, go to DONE next cycle, which drops div_valid. Otherwise idx advances and new operands appear the next cycle.
  - No idle cycle is inserted between elements.
- DONE:
  - res_valid=1; res_data=buffer; div_valid=0.
  - On res_ready, go to IDLE next cycle; uop_ready returns to 1 in that cycle.
  - No uop is accepted in DONE.
- Masked-off elements (vm[i]=0): buffer[i]=vd_old[i]; the divider result for i is discarded if issued.
- Divider corner results pass through unchanged: divide by zero gives quotient all-ones and remainder=dividend; signed most-negative/−1 gives quotient=most-negative and remainder=0.
- Flush:
  - trap_flush_rvv in any state moves to IDLE next cycle.
  - Buffer contents are discarded and the output buffer is zeroed; res_valid=0 and div_valid=0 from next cycle.
  - A uop_valid in the same cycle as a flush is not accepted.
- Simultaneous res_ready & trap_flush in DONE: counts as flushed; the consumer must ignore the beat.
- Reset mid-operation: immediate return to reset values.

Optional Feature:
- Macro: DIV_SEQ_MASK_SKIP_EN.
- Defined: elements with vm=0 are never issued; idx skips to the next active element via a priority search over the remaining mask bits. An all-masked uop goes from IDLE directly to DONE in 1 cycle.
- Undefined: every element is issued in order regardless of mask; masked results are discarded. Latency does not depend on the mask.

Test Plan:
- Unsigned quotient: NUM_ELEM=4, ELEM_WIDTH=32, src2={100,7,0xFFFFFFFF,9}, src1={7,7,1,10}, rem=0, vm=4'hF -> res_data={14,1,0xFFFFFFFF,0}. div_valid stays high until the 4th result handshake, then drops the cycle DONE is entered.
- Signed remainder with corners: src2={0x80000000,-7,5,-9}, src1={0xFFFFFFFF,2,0,-4}, signed=1, rem=1 -> res_data={0,-1,5,-1}.
- Mask: vm=4'b0101, vd_old all 0xDEADBEEF, src2=20, src1=3, quotient -> elements 0 and 2 = 6, elements 1 and 3 = 0xDEADBEEF. With DIV_SEQ_MASK_SKIP_EN, only 2 div_valid element handshakes occur; without it, 4.
- Backpressure: hold res_ready=0 for 10 cycles in DONE -> res_valid and res_data stable, uop_ready=0, div_valid=0. Release -> IDLE next cycle.
- Flush mid-ISSUE: assert trap_flush_rvv during element 2 -> next cycle IDLE, div_valid=0, res_valid=0. A new uop issued immediately afterwards completes with correct results.
- Reset mid-DONE: deassert rst_n -> res_valid=0 and uop_ready=1 immediately, without waiting for clk.
